median_window_sched: RTL and testbench

- Scheduler that turns a raster pixel stream into 3x3 windows and sequences the shared 9-sample median engine: one 9-sample burst per window, then wait for the engine result.
- Sits between the pixel source and the median engine, which keeps its own clock and reset.
- Emits one filtered pixel per interior image position, plus an end-of-frame pulse.

---
 rtl/median_pkg.sv | 32 +++
 rtl/median_line_buf.sv | 29 ++
 rtl/median_window_sched.sv | 180 ++++++++++++++++++
 tb/tb_median_window_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median window scheduler.
package median_pkg;

  // Scheduler FSM states, shared by the top and anything that observes it.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    OUT
  } state_t;

  // Samples in one 3x3 window burst to the median engine.
  localparam int WIN_N = 9;

  // Default geometry and engine timeout.
  localparam int DEF_W     = 8;
  localparam int DEF_IMG_W = 16;
  localparam int DEF_IMG_H = 16;
  localparam int DEF_TMO   = 64;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter widths for the default geometry.
  localparam int COL_CW  = cnt_width(DEF_IMG_W);
  localparam int ROW_CW  = cnt_width(DEF_IMG_H);
  localparam int TMO_CW  = cnt_width(DEF_TMO);
  localparam int LOAD_CW = cnt_width(WIN_N);

endpackage

// File: rtl/median_line_buf.sv
// One line of pixel history: single write and same-address read per accepted pixel.
module median_line_buf
  import median_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  // Storage is deliberately unreset: a column is always written before any window uses it.
  logic [W-1:0] mem [DEPTH];

  // The read returns the old contents, so a write and read of one column form a shift.
  assign rdata = mem[addr];

  // Store the new pixel for this column when a pixel is accepted.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/median_window_sched.sv
// Builds 3x3 windows from a raster pixel stream and sequences the shared
// 9-sample median engine: one burst per window, then wait for its result.
module median_window_sched
  import median_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int TMO   = DEF_TMO
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [W-1:0] PIX_I,
  input  logic         PIX_V,
  input  logic         PIX_SOF,
  output logic         PIX_R,
  output logic [W-1:0] MED_DI,
  output logic         MED_DSI,
  input  logic [W-1:0] MED_DO,
  input  logic         MED_DSO,
  output logic [W-1:0] PIX_O,
  output logic         PIX_OV,
  output logic         FRAME_DONE,
  output logic         ERR
);

  localparam int CW  = cnt_width(IMG_W);
  localparam int RW  = cnt_width(IMG_H);
  localparam int TW  = cnt_width(TMO);
  localparam int LCW = cnt_width(WIN_N);

  localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0]  COL_MIN   = CW'(2);
  localparam logic [RW-1:0]  ROW_MIN   = RW'(2);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TMO - 1);
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(WIN_N - 1);
  localparam logic [LCW-1:0] LOAD_ONE  = LCW'(1);

  state_t         state;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [RW-1:0]  cur_row;
  logic [CW-1:0]  cur_col;
  logic           accept;
  logic           completing;
  logic [W-1:0]   l1_rd;
  logic [W-1:0]   l2_rd;
  logic [W-1:0]   win [WIN_N];
  logic [LCW-1:0] load_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           last_win;

  // A start-of-frame pixel is pinned to the origin regardless of the tracked position.
  assign accept     = PIX_V && PIX_R;
  assign cur_col    = PIX_SOF ? '0 : col;
  assign cur_row    = PIX_SOF ? '0 : row;
  assign completing = (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);

  // L1 holds the previous line; L2 receives what L1 held, giving the line before that.
  median_line_buf #(
    .W     (W),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_l1 (
    .CLK   (CLK),
    .we    (accept),
    .addr  (cur_col),
    .wdata (PIX_I),
    .rdata (l1_rd)
  );

  median_line_buf #(
    .W     (W),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_l2 (
    .CLK   (CLK),
    .we    (accept),
    .addr  (cur_col),
    .wdata (l1_rd),
    .rdata (l2_rd)
  );

  // Raster position of the next pixel: column wraps into the row, row wraps at frame end.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Slide the 3x3 window left and bring in the new column {L2, L1, pixel}, top to bottom.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r*3]     <= win[r*3 + 1];
        win[r*3 + 1] <= win[r*3 + 2];
      end
      win[2] <= l2_rd;
      win[5] <= l1_rd;
      win[8] <= PIX_I;
    end
  end

  // Scheduler FSM: burst the window to the engine, wait for the result, emit it.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      PIX_R      <= 1'b0;
      MED_DSI    <= 1'b0;
      MED_DI     <= '0;
      PIX_O      <= '0;
      PIX_OV     <= 1'b0;
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;
      load_cnt   <= '0;
      tmo_cnt    <= '0;
      last_win   <= 1'b0;
    end else begin
      PIX_OV     <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          PIX_R <= 1'b1;
          if (accept && completing) begin
            // The window shifts on this same edge, so the new top-left is the old win[1].
            state    <= LOAD;
            PIX_R    <= 1'b0;
            MED_DSI  <= 1'b1;
            MED_DI   <= win[1];
            load_cnt <= '0;
            last_win <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
          end
        end
        LOAD: begin
          if (load_cnt == LOAD_LAST) begin
            state   <= WAIT;
            MED_DSI <= 1'b0;
            MED_DI  <= '0;
            tmo_cnt <= '0;
          end else begin
            load_cnt <= load_cnt + LOAD_ONE;
            MED_DI   <= win[load_cnt + LOAD_ONE];
          end
        end
        WAIT: begin
          if (MED_DSO) begin
            state      <= OUT;
            PIX_O      <= MED_DO;
            PIX_OV     <= 1'b1;
            FRAME_DONE <= last_win;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= IDLE;
            PIX_R <= 1'b1;
            ERR   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        OUT: begin
          state <= IDLE;
          PIX_R <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_sched.sv
// Self-checking bench for median_window_sched on a 4x4 image with a behavioural median engine.
module tb_median_window_sched;

  localparam int W    = 8;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int TMO  = 64;
  localparam int NPIX = IW * IH;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [W-1:0] PIX_I = '0;
  logic         PIX_V = 1'b0;
  logic         PIX_SOF = 1'b0;
  logic         PIX_R;
  logic [W-1:0] MED_DI;
  logic         MED_DSI;
  logic [W-1:0] MED_DO = '0;
  logic         MED_DSO = 1'b0;
  logic [W-1:0] PIX_O;
  logic         PIX_OV;
  logic         FRAME_DONE;
  logic         ERR;

  int errors = 0;
  int checks = 0;

  // Engine model state
  int  eng_samp[$];
  int  eng_dly = 0;
  int  eng_hold_left = 0;
  int  eng_hold_n = 1;
  bit  eng_respond = 1'b1;
  int  eng_med = 0;

  // Observed traffic
  int  burst_log[$];
  int  got_val[$];
  bit  got_fd[$];
  int  stray_fd = 0;
  int  dsi_runs[$];
  int  dsi_len = 0;
  int  rlow_runs[$];
  int  rlow_len = 0;

  // Expected traffic and stimulus
  int  exp_val[$];
  bit  exp_fd[$];
  int  exp_burst[$];
  int  img[NPIX];
  int  feed_px[$];
  bit  feed_sof[$];

  median_window_sched #(
    .W     (W),
    .IMG_W (IW),
    .IMG_H (IH),
    .TMO   (TMO)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .PIX_I      (PIX_I),
    .PIX_V      (PIX_V),
    .PIX_SOF    (PIX_SOF),
    .PIX_R      (PIX_R),
    .MED_DI     (MED_DI),
    .MED_DSI    (MED_DSI),
    .MED_DO     (MED_DO),
    .MED_DSO    (MED_DSO),
    .PIX_O      (PIX_O),
    .PIX_OV     (PIX_OV),
    .FRAME_DONE (FRAME_DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  // Median of nine values: sort and take the middle one.
  function automatic int med9(input int q[$]);
    int a[9];
    int t;
    for (int i = 0; i < 9; i++) a[i] = q[i];
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    end
    return a[4];
  endfunction

  // Median engine: collects 9 strobed samples, answers 5 cycles after the 9th.
  always @(negedge CLK) begin
    if (nRST !== 1'b1) begin
      eng_samp.delete();
      eng_dly = 0;
      eng_hold_left = 0;
      MED_DSO = 1'b0;
    end else begin
      if (eng_hold_left > 0) begin
        eng_hold_left--;
        if (eng_hold_left == 0) MED_DSO = 1'b0;
      end
      if (eng_dly > 0) begin
        eng_dly--;
        if (eng_dly == 0) begin
          MED_DSO = 1'b1;
          MED_DO = 8'(eng_med);
          eng_hold_left = eng_hold_n;
        end
      end
      if (MED_DSI === 1'b1) begin
        eng_samp.push_back(int'(MED_DI));
        burst_log.push_back(int'(MED_DI));
        if (eng_samp.size() == 9) begin
          if (eng_respond) begin
            eng_med = med9(eng_samp);
            eng_dly = 5;
          end
          eng_samp.delete();
        end
      end
    end
  end

  // Output and handshake monitor.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (PIX_OV === 1'b1) begin
        got_val.push_back(int'(PIX_O));
        got_fd.push_back(FRAME_DONE === 1'b1);
      end else if (FRAME_DONE === 1'b1) begin
        stray_fd++;
      end
      if (MED_DSI === 1'b1) dsi_len++;
      else if (dsi_len > 0) begin dsi_runs.push_back(dsi_len); dsi_len = 0; end
      if (PIX_R === 1'b0) rlow_len++;
      else if (rlow_len > 0) begin rlow_runs.push_back(rlow_len); rlow_len = 0; end
    end else begin
      dsi_len = 0;
      rlow_len = 0;
    end
  end

  task automatic clear_logs();
    burst_log.delete(); got_val.delete(); got_fd.delete();
    dsi_runs.delete(); rlow_runs.delete();
    exp_val.delete(); exp_fd.delete(); exp_burst.delete();
    stray_fd = 0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    PIX_V = 1'b0;
    PIX_SOF = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    clear_logs();
  endtask

  task automatic build_ramp();
    for (int i = 0; i < NPIX; i++) img[i] = i;
  endtask

  task automatic build_random();
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
  endtask

  task automatic queue_frame(input int npix);
    for (int i = 0; i < npix; i++) begin
      feed_px.push_back(img[i]);
      feed_sof.push_back(i == 0);
    end
  endtask

  // Reference: every interior centre in raster order, its row-major window and median.
  task automatic model_frame();
    int v[$];
    for (int r = 1; r < IH - 1; r++) begin
      for (int c = 1; c < IW - 1; c++) begin
        v.delete();
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            v.push_back(img[(r + dr) * IW + (c + dc)]);
        foreach (v[k]) exp_burst.push_back(v[k]);
        exp_val.push_back(med9(v));
        exp_fd.push_back((r == IH - 2) && (c == IW - 2));
      end
    end
  endtask

  // Present queued pixels, advancing only when the DUT is ready; bounded.
  task automatic feed();
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    while (idx < feed_px.size() && budget < 3000) begin
      @(negedge CLK);
      PIX_V = 1'b1;
      PIX_I = 8'(feed_px[idx]);
      PIX_SOF = feed_sof[idx];
      if (PIX_R === 1'b1) idx++;
      budget++;
    end
    @(negedge CLK);
    PIX_V = 1'b0;
    PIX_SOF = 1'b0;
    checks++;
    if (idx != feed_px.size()) begin
      errors++;
      $display("[TB] FAIL feed_budget accepted=%0d required=%0d", idx, feed_px.size());
    end
    feed_px.delete();
    feed_sof.delete();
  endtask

  task automatic drain();
    repeat (40) @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (PIX_R !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix_r got=%b exp=0", PIX_R); end
    checks++; if (PIX_OV !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix_ov got=%b exp=0", PIX_OV); end
    checks++; if (PIX_O !== 8'h00) begin errors++; $display("[TB] FAIL rst_pix_o got=%h exp=00", PIX_O); end
    checks++; if (MED_DSI !== 1'b0) begin errors++; $display("[TB] FAIL rst_med_dsi got=%b exp=0", MED_DSI); end
    checks++; if (MED_DI !== 8'h00) begin errors++; $display("[TB] FAIL rst_med_di got=%h exp=00", MED_DI); end
    checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done got=%b exp=0", FRAME_DONE); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got=%b exp=0", ERR); end
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (PIX_R !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_pix_r got=%b exp=1", PIX_R); end
    clear_logs();
  endtask

  task automatic test_ramp();
    int ramp_burst[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int ramp_out[4] = '{5, 6, 9, 10};
    build_ramp();
    queue_frame(NPIX);
    feed();
    drain();
    checks++; if (got_val.size() != 4) begin errors++; $display("[TB] FAIL ramp_count got=%0d exp=4", got_val.size()); end
    for (int i = 0; i < 4 && i < got_val.size(); i++) begin
      checks++;
      if (got_val[i] !== ramp_out[i] || got_fd[i] !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL ramp_out[%0d] got=%0d fd=%0b exp=%0d fd=%0b", i, got_val[i], got_fd[i], ramp_out[i], i == 3);
      end
    end
    checks++; if (burst_log.size() < 9) begin errors++; $display("[TB] FAIL ramp_burst_len got=%0d exp>=9", burst_log.size()); end
    for (int i = 0; i < 9 && i < burst_log.size(); i++) begin
      checks++;
      if (burst_log[i] !== ramp_burst[i]) begin
        errors++;
        $display("[TB] FAIL ramp_burst[%0d] got=%0d exp=%0d", i, burst_log[i], ramp_burst[i]);
      end
    end
    checks++; if (stray_fd != 0) begin errors++; $display("[TB] FAIL ramp_stray_fd got=%0d exp=0", stray_fd); end
    clear_logs();
  endtask

  task automatic test_constant();
    for (int i = 0; i < NPIX; i++) img[i] = 'h55;
    queue_frame(NPIX);
    feed();
    drain();
    checks++; if (got_val.size() != 4) begin errors++; $display("[TB] FAIL const_count got=%0d exp=4", got_val.size()); end
    foreach (got_val[i]) begin
      checks++;
      if (got_val[i] !== 'h55) begin errors++; $display("[TB] FAIL const_out[%0d] got=%0h exp=55", i, got_val[i]); end
    end
    checks++; if (dsi_runs.size() != 4) begin errors++; $display("[TB] FAIL const_dsi_runs got=%0d exp=4", dsi_runs.size()); end
    foreach (dsi_runs[i]) begin
      checks++;
      if (dsi_runs[i] != 9) begin errors++; $display("[TB] FAIL const_dsi_len[%0d] got=%0d exp=9", i, dsi_runs[i]); end
    end
    // Busy span per window: 9 load, 5 waiting on the engine, 1 output.
    checks++; if (rlow_runs.size() != 4) begin errors++; $display("[TB] FAIL const_rlow_runs got=%0d exp=4", rlow_runs.size()); end
    foreach (rlow_runs[i]) begin
      checks++;
      if (rlow_runs[i] != 15) begin errors++; $display("[TB] FAIL const_rlow_len[%0d] got=%0d exp=15", i, rlow_runs[i]); end
    end
    clear_logs();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      build_random();
      queue_frame(NPIX);
      model_frame();
    end
    feed();
    drain();
    checks++; if (got_val.size() != exp_val.size()) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", got_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++;
      if (got_val[i] !== exp_val[i] || got_fd[i] !== exp_fd[i]) begin
        errors++;
        $display("[TB] FAIL b2b_out[%0d] got=%0d fd=%0b exp=%0d fd=%0b", i, got_val[i], got_fd[i], exp_val[i], exp_fd[i]);
      end
    end
    checks++; if (burst_log.size() != exp_burst.size()) begin errors++; $display("[TB] FAIL b2b_burst_len got=%0d exp=%0d", burst_log.size(), exp_burst.size()); end
    for (int i = 0; i < exp_burst.size() && i < burst_log.size(); i++) begin
      checks++;
      if (burst_log[i] !== exp_burst[i]) begin
        errors++;
        $display("[TB] FAIL b2b_burst[%0d] got=%0d exp=%0d", i, burst_log[i], exp_burst[i]);
      end
    end
    clear_logs();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    eng_respond = 1'b0;
    build_ramp();
    queue_frame(11);
    feed();
    n = 0;
    while (MED_DSI === 1'b1 && n < 20) begin @(negedge CLK); n++; end
    n = 0;
    while (ERR !== 1'b1 && n < 200) begin n++; @(negedge CLK); end
    checks++; if (n != TMO) begin errors++; $display("[TB] FAIL tmo_wait_cycles got=%0d exp=%0d", n, TMO); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err got=%b exp=1", ERR); end
    checks++; if (PIX_R !== 1'b1) begin errors++; $display("[TB] FAIL tmo_pix_r got=%b exp=1", PIX_R); end
    checks++; if (got_val.size() != 0) begin errors++; $display("[TB] FAIL tmo_no_ov got=%0d exp=0", got_val.size()); end
    eng_respond = 1'b1;
    clear_logs();
    build_random();
    queue_frame(NPIX);
    model_frame();
    feed();
    drain();
    checks++; if (got_val.size() != 4) begin errors++; $display("[TB] FAIL tmo_after_count got=%0d exp=4", got_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++;
      if (got_val[i] !== exp_val[i]) begin errors++; $display("[TB] FAIL tmo_after_out[%0d] got=%0d exp=%0d", i, got_val[i], exp_val[i]); end
    end
    checks++; if (ERR !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err_sticky got=%b exp=1", ERR); end
    do_reset();
    checks++; if (ERR !== 1'b0) begin errors++; $display("[TB] FAIL tmo_err_cleared got=%b exp=0", ERR); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    build_ramp();
    queue_frame(11);
    feed();
    repeat (3) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    checks++; if (MED_DSI !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_dsi got=%b exp=0", MED_DSI); end
    checks++; if (MED_DI !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_di got=%h exp=00", MED_DI); end
    checks++; if (PIX_R !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_pix_r got=%b exp=0", PIX_R); end
    checks++; if (PIX_OV !== 1'b0 || PIX_O !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_pix_o got=%b/%h exp=0/00", PIX_OV, PIX_O); end
    checks++; if (FRAME_DONE !== 1'b0 || ERR !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_flags got=%b/%b exp=0/0", FRAME_DONE, ERR); end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    clear_logs();
    build_ramp();
    queue_frame(NPIX);
    model_frame();
    feed();
    drain();
    checks++; if (got_val.size() != 4) begin errors++; $display("[TB] FAIL mid_rst_count got=%0d exp=4", got_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++;
      if (got_val[i] !== exp_val[i] || got_fd[i] !== exp_fd[i]) begin
        errors++;
        $display("[TB] FAIL mid_rst_out[%0d] got=%0d fd=%0b exp=%0d fd=%0b", i, got_val[i], got_fd[i], exp_val[i], exp_fd[i]);
      end
    end
    clear_logs();
  endtask

  task automatic test_mid_sof();
    for (int i = 0; i < 5; i++) begin
      feed_px.push_back(int'($urandom_range(0, 255)));
      feed_sof.push_back(i == 0);
    end
    build_ramp();
    queue_frame(NPIX);
    model_frame();
    feed();
    drain();
    checks++; if (got_val.size() != 4) begin errors++; $display("[TB] FAIL sof_count got=%0d exp=4", got_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++;
      if (got_val[i] !== exp_val[i] || got_fd[i] !== exp_fd[i]) begin
        errors++;
        $display("[TB] FAIL sof_out[%0d] got=%0d fd=%0b exp=%0d fd=%0b", i, got_val[i], got_fd[i], exp_val[i], exp_fd[i]);
      end
    end
    clear_logs();
  endtask

  task automatic test_dso_hold();
    eng_hold_n = 4;
    build_random();
    queue_frame(NPIX);
    model_frame();
    feed();
    drain();
    checks++; if (got_val.size() != 4) begin errors++; $display("[TB] FAIL hold_count got=%0d exp=4", got_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++;
      if (got_val[i] !== exp_val[i]) begin errors++; $display("[TB] FAIL hold_out[%0d] got=%0d exp=%0d", i, got_val[i], exp_val[i]); end
    end
    checks++; if (dsi_runs.size() != 4) begin errors++; $display("[TB] FAIL hold_dsi_runs got=%0d exp=4", dsi_runs.size()); end
    eng_hold_n = 1;
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_constant();
    test_back_to_back();
    test_dso_hold();
    test_mid_sof();
    test_timeout();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
